// File: rtl/decode_pipe.sv
// Single-slot RV32I/RV64I-subset decoder; every out_* field is registered, one cycle after the input transfer.
// in_ready drops on output back-pressure, load-use hazard, flush or reset; flush empties the slot at once.
module decode_pipe #(
    parameter int XLEN      = 32,
    parameter int HAZARD_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_alu_op,
    output logic [7:0]      out_ctrl,
    output logic            out_illegal,
    output logic            out_flush_req,
    output logic [15:0]     dec_count
);

    localparam bit IS64 = (XLEN == 64);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_NOP   = 4'd0;
    localparam logic [3:0] ALU_ADD   = 4'd1;
    localparam logic [3:0] ALU_SUB   = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_OR    = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SLL   = 4'd6;
    localparam logic [3:0] ALU_SRL   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_SLT   = 4'd9;
    localparam logic [3:0] ALU_SLTU  = 4'd10;
    localparam logic [3:0] ALU_PASSB = 4'd11;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [6:0]      r_opcode;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_imm;
    logic [3:0]      r_alu_op;
    logic [7:0]      r_ctrl;
    logic            r_illegal;
    logic            r_flush_req;
    logic [15:0]     r_count;

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt;
    logic            w_sh_zero;
    logic            w_sh_alt;
    logic [3:0]      w_f3_alu;
    logic [3:0]      w_alu_op;
    logic [7:0]      w_ctrl;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;
    logic [4:0]      w_rs1;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_hazard;
    logic            w_in_xfer;

    assign w_opc = in_instr[6:0];
    assign w_f3  = in_instr[14:12];
    assign w_f7  = in_instr[31:25];

    assign w_imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign w_imm_u = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};

    // RV64 shift immediates carry a 6-bit shamt, so the function field above it shrinks to 6 bits
    assign w_shamt   = IS64 ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
    assign w_sh_zero = IS64 ? (in_instr[31:26] == 6'b000000) : (w_f7 == 7'b0000000);
    assign w_sh_alt  = IS64 ? (in_instr[31:26] == 6'b010000) : (w_f7 == 7'b0100000);

    always_comb begin
        case (w_f3)
            3'b000:  w_f3_alu = ALU_ADD;
            3'b001:  w_f3_alu = ALU_SLL;
            3'b010:  w_f3_alu = ALU_SLT;
            3'b011:  w_f3_alu = ALU_SLTU;
            3'b100:  w_f3_alu = ALU_XOR;
            3'b101:  w_f3_alu = ALU_SRL;
            3'b110:  w_f3_alu = ALU_OR;
            default: w_f3_alu = ALU_AND;
        endcase
    end

    always_comb begin
        w_alu_op  = ALU_NOP;
        w_ctrl    = 8'h00;
        w_illegal = 1'b0;
        w_imm     = '0;
        w_rs1     = in_instr[19:15];
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opc)
            OPC_R: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_ctrl    = 8'h80;
                if (w_f7 == 7'b0000000)
                    w_alu_op = w_f3_alu;
                else if (w_f7 == 7'b0100000 && w_f3 == 3'b000)
                    w_alu_op = ALU_SUB;
                else if (w_f7 == 7'b0100000 && w_f3 == 3'b101)
                    w_alu_op = ALU_SRA;
                else
                    w_illegal = 1'b1;
            end
            OPC_I: begin
                w_use_rs1 = 1'b1;
                w_ctrl    = 8'hC0;
                w_alu_op  = w_f3_alu;
                w_imm     = w_imm_i;
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    w_imm = w_shamt;
                    if (w_f3 == 3'b101 && w_sh_alt)
                        w_alu_op = ALU_SRA;
                    else if (!w_sh_zero)
                        w_illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                w_use_rs1 = 1'b1;
                w_ctrl    = 8'hF0;
                w_alu_op  = ALU_ADD;
                w_imm     = w_imm_i;
                w_illegal = (w_f3 == 3'b111) || (!IS64 && (w_f3 == 3'b011 || w_f3 == 3'b110));
            end
            OPC_STORE: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_ctrl    = 8'h48;
                w_alu_op  = ALU_ADD;
                w_imm     = w_imm_s;
                w_illegal = w_f3[2] || (!IS64 && w_f3 == 3'b011);
            end
            OPC_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_ctrl    = 8'h04;
                w_alu_op  = ALU_SUB;
                w_imm     = w_imm_b;
                w_illegal = (w_f3[2:1] == 2'b01);
            end
            OPC_JAL: begin
                w_ctrl = 8'h82;
                w_imm  = w_imm_j;
            end
            OPC_JALR: begin
                w_use_rs1 = 1'b1;
                w_ctrl    = 8'hC3;
                w_alu_op  = ALU_ADD;
                w_imm     = w_imm_i;
                w_illegal = (w_f3 != 3'b000);
            end
            OPC_LUI: begin
                w_ctrl   = 8'hC0;
                w_alu_op = ALU_PASSB;
                w_imm    = w_imm_u;
                w_rs1    = 5'd0;
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_ctrl   = 8'h00;
            w_alu_op = ALU_NOP;
        end
    end

    // Load in the output slot whose rd feeds the incoming instruction: hold it back one cycle
    assign w_hazard = (HAZARD_EN != 0) && r_valid && r_ctrl[4] && (r_rd != 5'd0) && in_valid &&
                      ((w_use_rs1 && in_instr[19:15] == r_rd) || (w_use_rs2 && in_instr[24:20] == r_rd));

    assign in_ready  = !rst && (!r_valid || out_ready) && !w_hazard && !flush;
    assign w_in_xfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_opcode    <= '0;
            r_funct3    <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_alu_op    <= ALU_NOP;
            r_ctrl      <= '0;
            r_illegal   <= 1'b0;
            r_flush_req <= 1'b0;
            r_count     <= '0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_flush_req <= 1'b0;
        end else if (w_in_xfer) begin
            r_valid     <= 1'b1;
            r_pc        <= in_pc;
            r_opcode    <= w_opc;
            r_funct3    <= w_f3;
            r_rs1       <= w_rs1;
            r_rs2       <= in_instr[24:20];
            r_rd        <= in_instr[11:7];
            r_imm       <= w_imm;
            r_alu_op    <= w_alu_op;
            r_ctrl      <= w_ctrl;
            r_illegal   <= w_illegal;
            r_flush_req <= w_ctrl[1] | w_ctrl[0];
            if (r_count != 16'hFFFF)
                r_count <= r_count + 16'd1;
        end else if (r_valid && out_ready) begin
            r_valid     <= 1'b0;
            r_flush_req <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign out_pc        = r_pc;
    assign out_opcode    = r_opcode;
    assign out_funct3    = r_funct3;
    assign out_rs1       = r_rs1;
    assign out_rs2       = r_rs2;
    assign out_rd        = r_rd;
    assign out_imm       = r_imm;
    assign out_alu_op    = r_alu_op;
    assign out_ctrl      = r_ctrl;
    assign out_illegal   = r_illegal;
    assign out_flush_req = r_flush_req;
    assign dec_count     = r_count;

endmodule
